// File: rtl/imem_responder_if.sv
// Fetch request/response bundle between an instruction requester (master)
// and the instruction memory responder (slave).
interface imem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic [31:0] rsp_addr;
  logic        rsp_err;
  logic        flush;

  modport master (
    output req_valid, req_addr, rsp_ready, flush,
    input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, flush,
    output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
  );
endinterface

// File: rtl/imem_responder.sv
// Instruction memory responder: registered word read into a 2-entry response FIFO.
// Define IMEM_PROG_PORT_EN to compile in the prog_* word write port.
module imem_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
  input logic             clk,
  input logic             reset,
  imem_responder_if.slave bus
`ifdef IMEM_PROG_PORT_EN
  ,
  input logic             prog_we,
  input logic [31:0]      prog_addr,
  input logic [31:0]      prog_wdata
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } entry_t;

  entry_t      head;
  entry_t      tail;
  entry_t      fresh;
  logic [1:0]  count;
  logic        push;
  logic        pop;
  logic        addr_bad;
  logic [31:0] rd_word;

  assign addr_bad = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr[31:AW+2] != '0);

`ifdef IMEM_PROG_PORT_EN
  logic [31:0] mem [DEPTH_WORDS] = '{default: NOP_WORD};
  logic        prog_ok;

  assign prog_ok = (prog_addr[1:0] == 2'b00) && (prog_addr[31:AW+2] == '0);
  assign rd_word = mem[bus.req_addr[AW+1:2]];

  // No reset here: the array keeps its contents across reset and flush.
  always_ff @(posedge clk) begin
    if (prog_we && prog_ok) begin
      mem[prog_addr[AW+1:2]] <= prog_wdata;
    end
  end
`else
  assign rd_word = NOP_WORD;
`endif

  always_comb begin
    fresh       = '0;
    fresh.instr = addr_bad ? NOP_WORD : rd_word;
    fresh.addr  = bus.req_addr;
    fresh.err   = addr_bad;
  end

  // A full FIFO can still take a request when the head is popped in the same cycle.
  assign bus.req_ready = !reset && !bus.flush && ((count != 2'd2) || bus.rsp_ready);
  assign push          = bus.req_valid && bus.req_ready;
  assign pop           = bus.rsp_valid && bus.rsp_ready;

  assign bus.rsp_valid = (count != 2'd0);
  assign bus.rsp_instr = head.instr;
  assign bus.rsp_addr  = head.addr;
  assign bus.rsp_err   = head.err;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else if (bus.flush) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= fresh;
          else               tail <= fresh;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head <= fresh;
          end else begin
            head <= tail;
            tail <= fresh;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Directed, table-driven bench for imem_responder (default DEPTH_WORDS=256).
// Extra prog-port sequences run when IMEM_PROG_PORT_EN is defined.
module tb_imem_responder;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  imem_responder_if bus ();

`ifdef IMEM_PROG_PORT_EN
  logic        prog_we;
  logic [31:0] prog_addr;
  logic [31:0] prog_wdata;
`endif

  imem_responder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
`ifdef IMEM_PROG_PORT_EN
    ,
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_wdata (prog_wdata)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        v;
    logic [31:0] a;
    logic        rr;
    logic        fl;
    logic        e_rdy;
    logic        e_rv;
    logic        chk;
    logic [31:0] e_addr;
    logic        e_err;
    logic [31:0] e_instr;
  } vec_t;

  vec_t vecs[33];

  task automatic applyStimulus(input logic rst, input logic v, input logic [31:0] a,
                               input logic rr, input logic fl);
    @(posedge clk);
    #1;
    reset         = rst;
    bus.req_valid = v;
    bus.req_addr  = a;
    bus.rsp_ready = rr;
    bus.flush     = fl;
  endtask

  task automatic checkOutput(input string name, input logic e_rdy, input logic e_rv,
                             input logic chk, input logic [31:0] e_addr,
                             input logic e_err, input logic [31:0] e_instr);
    @(negedge clk);
    checks++;
    if (bus.req_ready !== e_rdy) begin
      errors++;
      $display("[TB] FAIL %s req_ready got %b want %b", name, bus.req_ready, e_rdy);
    end
    checks++;
    if (bus.rsp_valid !== e_rv) begin
      errors++;
      $display("[TB] FAIL %s rsp_valid got %b want %b", name, bus.rsp_valid, e_rv);
    end
    if (chk) begin
      checks++;
      if (bus.rsp_addr !== e_addr) begin
        errors++;
        $display("[TB] FAIL %s rsp_addr got %h want %h", name, bus.rsp_addr, e_addr);
      end
      checks++;
      if (bus.rsp_err !== e_err) begin
        errors++;
        $display("[TB] FAIL %s rsp_err got %b want %b", name, bus.rsp_err, e_err);
      end
      checks++;
      if (bus.rsp_instr !== e_instr) begin
        errors++;
        $display("[TB] FAIL %s rsp_instr got %h want %h", name, bus.rsp_instr, e_instr);
      end
    end
  endtask

`ifdef IMEM_PROG_PORT_EN
  task automatic setProg(input logic we, input logic [31:0] a, input logic [31:0] d);
    prog_we    = we;
    prog_addr  = a;
    prog_wdata = d;
  endtask

  task automatic progSequence();
    applyStimulus(0, 0, 32'h0, 1, 0); setProg(1, 32'h0, 32'hA0);
    checkOutput("p_wr0", 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 32'h0, 1, 0); setProg(1, 32'h4, 32'hA1);
    checkOutput("p_wr1", 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 32'h0, 1, 0); setProg(1, 32'h8, 32'hA2);
    checkOutput("p_wr2", 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 32'h0, 1, 0); setProg(0, 32'h0, 32'h0);
    checkOutput("p_b2b0", 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 32'h4, 1, 0);
    checkOutput("p_b2b1", 1, 1, 1, 32'h0, 0, 32'hA0);
    applyStimulus(0, 1, 32'h8, 1, 0);
    checkOutput("p_b2b2", 1, 1, 1, 32'h4, 0, 32'hA1);
    applyStimulus(0, 1, 32'h10, 1, 0); setProg(1, 32'h10, 32'hDEAD_BEEF);
    checkOutput("p_b2b3", 1, 1, 1, 32'h8, 0, 32'hA2);
    applyStimulus(0, 1, 32'h10, 1, 0); setProg(0, 32'h0, 32'h0);
    checkOutput("p_readfirst", 1, 1, 1, 32'h10, 0, NOP);
    applyStimulus(0, 0, 32'h0, 1, 0); setProg(1, 32'h12, 32'h1234);
    checkOutput("p_reread", 1, 1, 1, 32'h10, 0, 32'hDEAD_BEEF);
    applyStimulus(0, 0, 32'h0, 1, 0); setProg(1, 32'h410, 32'h5678);
    checkOutput("p_idle0", 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 32'h10, 1, 0); setProg(0, 32'h0, 32'h0);
    checkOutput("p_idle1", 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 32'h0, 1, 0);
    checkOutput("p_badwr_ignored", 1, 1, 1, 32'h10, 0, 32'hDEAD_BEEF);
    applyStimulus(1, 1, 32'h0, 1, 0); setProg(1, 32'h20, 32'h55);
    checkOutput("p_rst_wr", 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 32'h0, 1, 0); setProg(0, 32'h0, 32'h0);
    checkOutput("p_post_rst", 1, 0, 1, 32'h0, 0, 32'h0);
    applyStimulus(0, 1, 32'h20, 1, 0);
    checkOutput("p_preserved", 1, 1, 1, 32'h0, 0, 32'hA0);
    applyStimulus(0, 0, 32'h0, 1, 0);
    checkOutput("p_wr_in_rst", 1, 1, 1, 32'h20, 0, 32'h55);
    applyStimulus(0, 0, 32'h0, 1, 0);
    checkOutput("p_drained", 1, 0, 0, 0, 0, 0);
  endtask
`endif

  initial begin
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr  = 32'h0;
    bus.rsp_ready = 1'b0;
    bus.flush     = 1'b0;
`ifdef IMEM_PROG_PORT_EN
    prog_we    = 1'b0;
    prog_addr  = 32'h0;
    prog_wdata = 32'h0;
`endif

    //           rst v  addr           rr fl  rdy rv chk addr           err instr
    vecs[0]  = '{0, 0, 32'h0,         1, 0,  1,  0, 1,  32'h0,         0,  32'h0};
    vecs[1]  = '{0, 1, 32'h0,         1, 0,  1,  0, 0,  32'h0,         0,  32'h0};
    vecs[2]  = '{0, 1, 32'h4,         1, 0,  1,  1, 1,  32'h0,         0,  NOP};
    vecs[3]  = '{0, 1, 32'h8,         1, 0,  1,  1, 1,  32'h4,         0,  NOP};
    vecs[4]  = '{0, 0, 32'h0,         1, 0,  1,  1, 1,  32'h8,         0,  NOP};
    vecs[5]  = '{0, 0, 32'h0,         1, 0,  1,  0, 0,  32'h0,         0,  32'h0};
    vecs[6]  = '{0, 1, 32'h2,         1, 0,  1,  0, 0,  32'h0,         0,  32'h0};
    vecs[7]  = '{0, 1, 32'h400,       1, 0,  1,  1, 1,  32'h2,         1,  NOP};
    vecs[8]  = '{0, 1, 32'h3FC,       1, 0,  1,  1, 1,  32'h400,       1,  NOP};
    vecs[9]  = '{0, 1, 32'h8000_0000, 1, 0,  1,  1, 1,  32'h3FC,       0,  NOP};
    vecs[10] = '{0, 0, 32'h0,         1, 0,  1,  1, 1,  32'h8000_0000, 1,  NOP};
    vecs[11] = '{0, 1, 32'h10,        0, 0,  1,  0, 0,  32'h0,         0,  32'h0};
    vecs[12] = '{0, 1, 32'h14,        0, 0,  1,  1, 1,  32'h10,        0,  NOP};
    vecs[13] = '{0, 1, 32'h18,        0, 0,  0,  1, 1,  32'h10,        0,  NOP};
    vecs[14] = '{0, 1, 32'h18,        0, 0,  0,  1, 1,  32'h10,        0,  NOP};
    vecs[15] = '{0, 1, 32'h18,        1, 0,  1,  1, 1,  32'h10,        0,  NOP};
    vecs[16] = '{0, 0, 32'h0,         1, 0,  1,  1, 1,  32'h14,        0,  NOP};
    vecs[17] = '{0, 0, 32'h0,         1, 0,  1,  1, 1,  32'h18,        0,  NOP};
    vecs[18] = '{0, 0, 32'h0,         1, 0,  1,  0, 0,  32'h0,         0,  32'h0};
    vecs[19] = '{0, 1, 32'h20,        0, 0,  1,  0, 0,  32'h0,         0,  32'h0};
    vecs[20] = '{0, 1, 32'h24,        0, 0,  1,  1, 1,  32'h20,        0,  NOP};
    vecs[21] = '{0, 1, 32'h28,        0, 1,  0,  1, 1,  32'h20,        0,  NOP};
    vecs[22] = '{0, 0, 32'h0,         1, 0,  1,  0, 0,  32'h0,         0,  32'h0};
    vecs[23] = '{0, 1, 32'h2C,        1, 0,  1,  0, 0,  32'h0,         0,  32'h0};
    vecs[24] = '{0, 0, 32'h0,         1, 0,  1,  1, 1,  32'h2C,        0,  NOP};
    vecs[25] = '{0, 0, 32'h0,         1, 0,  1,  0, 0,  32'h0,         0,  32'h0};
    vecs[26] = '{0, 1, 32'h30,        0, 0,  1,  0, 0,  32'h0,         0,  32'h0};
    vecs[27] = '{0, 1, 32'h34,        0, 0,  1,  1, 1,  32'h30,        0,  NOP};
    vecs[28] = '{1, 1, 32'h38,        0, 0,  0,  1, 1,  32'h30,        0,  NOP};
    vecs[29] = '{0, 0, 32'h0,         1, 0,  1,  0, 1,  32'h0,         0,  32'h0};
    vecs[30] = '{0, 1, 32'h3C,        1, 0,  1,  0, 0,  32'h0,         0,  32'h0};
    vecs[31] = '{0, 0, 32'h0,         1, 0,  1,  1, 1,  32'h3C,        0,  NOP};
    vecs[32] = '{0, 0, 32'h0,         1, 0,  1,  0, 0,  32'h0,         0,  32'h0};

    applyStimulus(1, 1, 32'h0, 1, 0);
    checkOutput("reset_state", 0, 0, 1, 32'h0, 0, 32'h0);

    for (int i = 0; i < 33; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].v, vecs[i].a, vecs[i].rr, vecs[i].fl);
      checkOutput($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_rv, vecs[i].chk,
                  vecs[i].e_addr, vecs[i].e_err, vecs[i].e_instr);
    end

    // Flush while full with the consumer ready must still refuse the request.
    applyStimulus(0, 1, 32'h40, 0, 0);
    checkOutput("fl2_fill0", 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 32'h44, 0, 0);
    checkOutput("fl2_fill1", 1, 1, 1, 32'h40, 0, NOP);
    applyStimulus(0, 1, 32'h48, 1, 1);
    checkOutput("fl2_flush", 0, 1, 1, 32'h40, 0, NOP);
    applyStimulus(0, 0, 32'h0, 1, 0);
    checkOutput("fl2_empty", 1, 0, 0, 0, 0, 0);

`ifdef IMEM_PROG_PORT_EN
    progSequence();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
